// File: rtl/mips_writeback_unit.sv
// Register-file write-back for ALU results (port c) and load data (port d),
// with an in-order load destination queue, WAW kill and a busy scoreboard.
module mips_writeback_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_dest,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  ld_offset,
  output logic        ld_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  write_addr_c,
  output logic        write_enable_c,
  output logic [31:0] write_data_c,
  output logic [4:0]  write_addr_d,
  output logic        write_enable_d,
  output logic [31:0] write_data_d,
  output logic [31:0] busy,
  output logic        err_overflow,
  output logic        err_unexpected
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] live_q, kill_q, live_nxt, kill_nxt;
  logic [4:0]       dest_q   [DEPTH];
  logic [2:0]       typ_q    [DEPTH];
  logic [1:0]       offset_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic alu_we, push, pop, head_kill, pop_we;

  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [2:0]  typ,
                                          input logic [1:0]  off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (typ)
      3'd1:    extract = 32'(b);
      3'd2:    extract = {24'd0, b};
      3'd3:    extract = 32'(h);
      3'd4:    extract = {16'd0, h};
      default: extract = word;
    endcase
  endfunction

  assign ld_ready = (count != CNT_W'(DEPTH));
  assign push     = ld_issue && ld_ready;
  assign pop      = mem_rvalid && (count != '0);
  assign alu_we   = alu_valid && (alu_addr != 5'd0);

  // Kills are applied to the pre-push queue, so the popping head sees them too.
  always_comb begin
    live_nxt = live_q;
    kill_nxt = kill_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && ((alu_we && dest_q[i] == alu_addr) ||
                        (push && dest_q[i] == ld_dest)))
        kill_nxt[i] = 1'b1;
    end
    head_kill = kill_nxt[rd_ptr];
    if (pop)
      live_nxt[rd_ptr] = 1'b0;
    if (push) begin
      live_nxt[wr_ptr] = 1'b1;
      kill_nxt[wr_ptr] = 1'b0;
    end
  end

  assign pop_we = pop && !head_kill && (dest_q[rd_ptr] != 5'd0) &&
                  !(alu_we && alu_addr == dest_q[rd_ptr]);

  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr]   <= ld_dest;
      typ_q[wr_ptr]    <= ld_type;
      offset_q[wr_ptr] <= ld_offset;
    end
  end

  // Output stage: both ports are registered one cycle after their source.
  always_ff @(posedge clk) begin
    if (reset) begin
      count          <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      live_q         <= '0;
      kill_q         <= '0;
      write_enable_c <= 1'b0;
      write_addr_c   <= '0;
      write_data_c   <= '0;
      write_enable_d <= 1'b0;
      write_addr_d   <= '0;
      write_data_d   <= '0;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      live_q <= live_nxt;
      kill_q <= kill_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      write_enable_c <= alu_we;
      write_addr_c   <= alu_addr;
      write_data_c   <= alu_data;
      write_enable_d <= pop_we;
      if (pop) begin
        write_addr_d <= dest_q[rd_ptr];
        write_data_d <= extract(mem_rdata, typ_q[rd_ptr], offset_q[rd_ptr]);
      end
      if (ld_issue && !ld_ready)
        err_overflow <= 1'b1;
      if (mem_rvalid && count == '0)
        err_unexpected <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && !kill_q[i])
        busy[dest_q[i]] = 1'b1;
    end
    if (write_enable_c)
      busy[write_addr_c] = 1'b1;
    if (write_enable_d)
      busy[write_addr_d] = 1'b1;
    busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_mips_writeback_unit.sv
// Bench for mips_writeback_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_mips_writeback_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_dest = '0;
  logic [2:0]  ld_type = '0;
  logic [1:0]  ld_offset = '0;
  logic        ld_ready;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  write_addr_c, write_addr_d;
  logic        write_enable_c, write_enable_d;
  logic [31:0] write_data_c, write_data_d;
  logic [31:0] busy;
  logic        err_overflow, err_unexpected;

  mips_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_dest(ld_dest), .ld_type(ld_type), .ld_offset(ld_offset),
    .ld_ready(ld_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .write_addr_c(write_addr_c), .write_enable_c(write_enable_c), .write_data_c(write_data_c),
    .write_addr_d(write_addr_d), .write_enable_d(write_enable_d), .write_data_d(write_data_d),
    .busy(busy), .err_overflow(err_overflow), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] dest;
    logic [2:0] typ;
    logic [1:0] off;
    bit         killed;
  } ent_t;

  ent_t        q[$];
  bit          m_started = 0;
  bit          m_zero = 0;
  bit          m_we_c = 0, m_we_d = 0, m_ovf = 0, m_unx = 0;
  logic [4:0]  m_addr_c = '0, m_addr_d = '0;
  logic [31:0] m_data_c = '0, m_data_d = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_extract(input logic [31:0] w, input logic [2:0] t,
                                            input logic [1:0] o);
    logic [31:0] b, h;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * o[1])) & 32'hFFFF;
    case (t)
      3'd1:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] r = '0;
    foreach (q[i]) if (!q[i].killed) r[q[i].dest] = 1'b1;
    if (m_we_c) r[m_addr_c] = 1'b1;
    if (m_we_d) r[m_addr_d] = 1'b1;
    r[0] = 1'b0;
    return r;
  endfunction

  task automatic model_step(input bit rst, input bit av, input logic [4:0] aa,
                            input logic [31:0] ad, input bit li, input logic [4:0] ldd,
                            input logic [2:0] lt, input logic [1:0] lo, input bit rv,
                            input logic [31:0] rd);
    ent_t e;
    bit   acc;
    if (rst) begin
      q.delete();
      m_we_c = 0; m_we_d = 0; m_ovf = 0; m_unx = 0;
      m_addr_c = '0; m_addr_d = '0; m_data_c = '0; m_data_d = '0;
      m_zero = 1; m_started = 1;
      return;
    end
    m_zero = 0;
    acc = li && (q.size() != DEPTH);
    if (li && !acc) m_ovf = 1;
    if (rv && q.size() == 0) m_unx = 1;
    foreach (q[i]) begin
      if (av && aa != 0 && q[i].dest == aa) q[i].killed = 1;
      if (acc && q[i].dest == ldd) q[i].killed = 1;
    end
    m_we_c = av && aa != 0;
    m_addr_c = aa;
    m_data_c = ad;
    m_we_d = 0;
    if (rv && q.size() > 0) begin
      e = q.pop_front();
      m_we_d = !e.killed && e.dest != 0 && !(m_we_c && aa == e.dest);
      m_addr_d = e.dest;
      m_data_d = m_extract(rd, e.typ, e.off);
    end
    if (acc) q.push_back('{dest: ldd, typ: lt, off: lo, killed: 0});
  endtask

  task automatic tick(input bit rst, input bit av, input logic [4:0] aa,
                      input logic [31:0] ad, input bit li, input logic [4:0] ldd,
                      input logic [2:0] lt, input logic [1:0] lo, input bit rv,
                      input logic [31:0] rd);
    @(negedge clk);
    reset = rst; alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_issue = li; ld_dest = ldd; ld_type = lt; ld_offset = lo;
    mem_rvalid = rv; mem_rdata = rd;
    #1;
    if (m_started) begin
      chk("ld_ready", {31'd0, ld_ready}, {31'd0, q.size() != DEPTH});
      chk("busy", busy, m_busy());
    end
    model_step(rst, av, aa, ad, li, ldd, lt, lo, rv, rd);
    @(posedge clk);
    #1;
    chk("we_c", {31'd0, write_enable_c}, {31'd0, m_we_c});
    chk("we_d", {31'd0, write_enable_d}, {31'd0, m_we_d});
    if (m_we_c || m_zero) begin
      chk("addr_c", {27'd0, write_addr_c}, {27'd0, m_addr_c});
      chk("data_c", write_data_c, m_data_c);
    end
    if (m_we_d || m_zero) begin
      chk("addr_d", {27'd0, write_addr_d}, {27'd0, m_addr_d});
      chk("data_d", write_data_d, m_data_d);
    end
    chk("err_overflow", {31'd0, err_overflow}, {31'd0, m_ovf});
    chk("err_unexpected", {31'd0, err_unexpected}, {31'd0, m_unx});
  endtask

  task automatic t_rst();  tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic t_idle(); tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic t_alu(input logic [4:0] a, input logic [31:0] d);
    tick(0, 1, a, d, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic t_issue(input logic [4:0] dst, input logic [2:0] ty, input logic [1:0] of);
    tick(0, 0, 0, 0, 1, dst, ty, of, 0, 0);
  endtask
  task automatic t_resp(input logic [31:0] d); tick(0, 0, 0, 0, 0, 0, 0, 0, 1, d); endtask

  initial begin
    bit          rst, av, li, rv;
    logic [4:0]  aa, ldd;
    logic [31:0] ad, rd;
    logic [2:0]  lt;
    logic [1:0]  lo;

    t_rst(); t_rst();
    chk("lit_rst_busy", busy, 32'd0);
    chk("lit_rst_ready", {31'd0, ld_ready}, 32'd1);

    t_alu(5'd5, 32'hDEADBEEF);
    chk("lit_alu_we", {31'd0, write_enable_c}, 32'd1);
    chk("lit_alu_addr", {27'd0, write_addr_c}, 32'd5);
    chk("lit_alu_data", write_data_c, 32'hDEADBEEF);
    chk("lit_alu_busy5", {31'd0, busy[5]}, 32'd1);
    t_idle();
    chk("lit_alu_busy5_clr", {31'd0, busy[5]}, 32'd0);
    t_alu(5'd0, 32'h12345678);
    chk("lit_alu0_we", {31'd0, write_enable_c}, 32'd0);
    chk("lit_alu0_busy", busy, 32'd0);

    t_issue(5'd8, 3'd1, 2'd3);
    t_issue(5'd9, 3'd4, 2'd2);
    t_resp(32'h80FF1234);
    chk("lit_lb_addr", {27'd0, write_addr_d}, 32'd8);
    chk("lit_lb_data", write_data_d, 32'hFFFFFF80);
    t_issue(5'd10, 3'd0, 2'd0);
    t_resp(32'h80FF1234);
    chk("lit_lhu_addr", {27'd0, write_addr_d}, 32'd9);
    chk("lit_lhu_data", write_data_d, 32'h000080FF);
    t_resp(32'h01020304);
    chk("lit_lw_addr", {27'd0, write_addr_d}, 32'd10);
    chk("lit_lw_data", write_data_d, 32'h01020304);

    t_issue(5'd11, 3'd0, 2'd0);
    t_issue(5'd12, 3'd0, 2'd0);
    chk("lit_full_ready", {31'd0, ld_ready}, 32'd0);
    t_issue(5'd13, 3'd0, 2'd0);
    chk("lit_full_ovf", {31'd0, err_overflow}, 32'd1);
    t_resp(32'hAAAA0001);
    chk("lit_full_d1", {27'd0, write_addr_d}, 32'd11);
    t_resp(32'hAAAA0002);
    chk("lit_full_d2", {27'd0, write_addr_d}, 32'd12);
    t_idle();
    chk("lit_full_nowrite", {31'd0, write_enable_d}, 32'd0);
    chk("lit_full_ready2", {31'd0, ld_ready}, 32'd1);

    t_issue(5'd7, 3'd0, 2'd0);
    t_alu(5'd7, 32'h55);
    chk("lit_waw_alu_we", {31'd0, write_enable_c}, 32'd1);
    t_idle();
    chk("lit_waw_busy7", {31'd0, busy[7]}, 32'd0);
    t_resp(32'h99);
    chk("lit_waw_killed", {31'd0, write_enable_d}, 32'd0);
    t_issue(5'd7, 3'd0, 2'd0);
    t_issue(5'd7, 3'd0, 2'd0);
    t_resp(32'h66);
    chk("lit_ll_first", {31'd0, write_enable_d}, 32'd0);
    t_resp(32'h77);
    chk("lit_ll_second", {31'd0, write_enable_d}, 32'd1);
    chk("lit_ll_data", write_data_d, 32'h77);

    t_issue(5'd4, 3'd0, 2'd0);
    tick(0, 1, 5'd4, 32'hA5A5A5A5, 0, 0, 0, 0, 1, 32'h11111111);
    chk("lit_col_c", {31'd0, write_enable_c}, 32'd1);
    chk("lit_col_d", {31'd0, write_enable_d}, 32'd0);
    chk("lit_col_data", write_data_c, 32'hA5A5A5A5);

    t_issue(5'd3, 3'd0, 2'd0);
    t_rst();
    chk("lit_mid_busy", busy, 32'd0);
    chk("lit_mid_ready", {31'd0, ld_ready}, 32'd1);
    t_resp(32'hBAD0BAD0);
    chk("lit_stray_we", {31'd0, write_enable_d}, 32'd0);
    chk("lit_stray_err", {31'd0, err_unexpected}, 32'd1);

    t_rst();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      av  = ($urandom_range(0, 1) == 1);
      aa  = 5'($urandom_range(0, 7));
      ad  = $urandom;
      li  = ($urandom_range(0, 99) < 45);
      ldd = 5'($urandom_range(0, 7));
      lt  = 3'($urandom_range(0, 7));
      lo  = 2'($urandom_range(0, 3));
      rv  = (q.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
      rd  = $urandom;
      tick(rst, av, aa, ad, li, ldd, lt, lo, rv, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
